// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port RAM between instruction fetch
// and data access; data has priority with bounded instruction starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  input  logic        ramerror,
  output logic        err
);

  localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;
  localparam logic [3:0]  DLIMIT   = 4'(STARVE_LIMIT);
  localparam logic [7:0]  TLAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tcount;
  logic [3:0]  dcount;
  logic        dreq, dgrant, igrant, timeout, complete, fault;

  always_comb begin
    dreq     = dWEN | dREN;
    dgrant   = dreq & ~(iREN & (dcount == DLIMIT));
    igrant   = iREN & ~dgrant;
    timeout  = (tcount == TLAST);
    complete = (state != IDLE) & (ramready | ramerror | timeout);
    // a ready arriving in the last watchdog cycle still counts as a good finish
    fault    = ramerror | (timeout & ~ramready);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iwait     = iREN & ~((state == IACC) & complete);
    dwait     = dreq & ~((state == DACC) & complete);
    iload     = '0;
    dload     = '0;
    case (state)
      IDLE: begin
        if (dgrant)      state_nxt = DACC;
        else if (igrant) state_nxt = IACC;
      end
      IACC: begin
        if (complete) begin
          state_nxt = IDLE;
          iload     = fault ? BAD_DATA : ramload;
        end
      end
      DACC: begin
        if (complete) begin
          state_nxt = IDLE;
          dload     = fault ? BAD_DATA : ramload;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      tcount   <= '0;
      dcount   <= '0;
      err      <= 1'b0;
    end else begin
      err <= complete & fault;
      if (state == IDLE) begin
        tcount <= '0;
        if (dgrant) begin
          ramaddr  <= daddr;
          ramstore <= dstore;
          ramWEN   <= dWEN;
          ramREN   <= dREN & ~dWEN;
        end else if (igrant) begin
          ramaddr  <= iaddr;
          ramWEN   <= 1'b0;
          ramREN   <= 1'b1;
        end
        if (igrant | ~iREN) dcount <= '0;
      end else if (complete) begin
        ramREN  <= 1'b0;
        ramWEN  <= 1'b0;
        ramaddr <= '0;
        tcount  <= '0;
        if ((state == DACC) && iREN && (dcount != DLIMIT)) dcount <= dcount + 4'd1;
      end else begin
        tcount <= tcount + 8'd1;
      end
    end
  end

endmodule
